ysyx_25020047_mem_arb: RTL and testbench

- Two-master, one-slave memory arbiter. It shares the single data-memory port between the IFU (instruction fetch, read-only) and the LSU (load/store).
- One outstanding transaction at a time. Round-robin between the two masters. A response-timeout watchdog returns an error response if the slave never answers.
- Sits between the IFU/LSU and the memory slave (DPI pmem bridge or SRAM model).

---
 rtl/ysyx_25020047_mem_pkg.sv | 25 ++
 rtl/ysyx_25020047_rr_arb2.sv | 49 ++++
 rtl/ysyx_25020047_mem_arb.sv | 177 +++++++++++++++++
 tb/tb_ysyx_25020047_mem_arb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25020047_mem_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: FSM states, master IDs
// and default bus widths.
package ysyx_25020047_mem_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic {
    M_IFU = 1'b0,
    M_LSU = 1'b1
  } master_e;

  // The master that did not receive the previous grant.
  function automatic master_e other_master(input master_e m);
    return (m == M_IFU) ? M_LSU : M_IFU;
  endfunction

endpackage

// File: rtl/ysyx_25020047_rr_arb2.sv
// Two-input round-robin grant. A single requester always wins; on contention
// the master that was not granted last time wins. last_grant starts at LSU so
// the IFU wins the first contention after reset.
module ysyx_25020047_rr_arb2
  import ysyx_25020047_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req_ifu,
  input  logic i_req_lsu,
  output logic o_gnt_valid,
  output logic o_gnt_id
);

  master_e r_last_grant;

  // Grant decision, combinational so the winner sees ready in the same cycle.
  // NOTE: every output of an always_comb gets a default first, otherwise a
  // path that skips an assignment infers a latch.
  always_comb begin
    o_gnt_valid = 1'b0;
    o_gnt_id    = M_IFU;
    if (i_en) begin
      if (i_req_ifu && i_req_lsu) begin
        o_gnt_valid = 1'b1;
        o_gnt_id    = other_master(r_last_grant);
      end else if (i_req_ifu) begin
        o_gnt_valid = 1'b1;
        o_gnt_id    = M_IFU;
      end else if (i_req_lsu) begin
        o_gnt_valid = 1'b1;
        o_gnt_id    = M_LSU;
      end
    end
  end

  // Remember who was granted last.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= M_LSU;
    end else if (o_gnt_valid) begin
      r_last_grant <= master_e'(o_gnt_id);
    end
  end

endmodule

// File: rtl/ysyx_25020047_mem_arb.sv
// Shares one memory slave port between the IFU (read-only) and the LSU.
// One outstanding transaction at a time, round-robin grant, and a response
// watchdog that answers with an error if the slave goes silent.
module ysyx_25020047_mem_arb
  import ysyx_25020047_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_rdata,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_rdata,
  output logic                lsu_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata,
  input  logic                mem_resp_err,
  output logic                spurious_resp
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

  state_e              r_state;
  state_e              w_state_nxt;
  master_e             r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_spurious;

  logic w_arb_en;
  logic w_gnt_valid;
  logic w_gnt_id;
  logic w_resp_fire;
  logic w_timeout;

  // Grants only happen in S_IDLE; reset suppresses any same-cycle handshake.
  assign w_arb_en = (r_state == S_IDLE) && !rst;

  ysyx_25020047_rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rst         (rst),
    .i_en        (w_arb_en),
    .i_req_ifu   (ifu_req_valid),
    .i_req_lsu   (lsu_req_valid),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  // A real response always beats the watchdog in the same cycle.
  assign w_resp_fire = (r_state == S_RESP) && mem_resp_valid && !rst;
  assign w_timeout   = (TIMEOUT != 0) && (r_state == S_RESP) && !mem_resp_valid
                       && (r_cnt == TO_LIM) && !rst;

  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_wdata     = r_wdata;
  assign mem_wmask     = r_wmask;
  assign spurious_resp = r_spurious;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake/response outputs.
  always_comb begin
    w_state_nxt    = r_state;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_resp_rdata = '0;
    ifu_resp_err   = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_resp_rdata = '0;
    lsu_resp_err   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_gnt_valid) begin
          w_state_nxt = S_REQ;
          if (w_gnt_id == M_IFU) ifu_req_ready = 1'b1;
          else                   lsu_req_ready = 1'b1;
        end
      end
      S_REQ: begin
        mem_req_valid = !rst;
        if (mem_req_ready) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (w_resp_fire || w_timeout) begin
          w_state_nxt = S_IDLE;
          if (r_owner == M_IFU) begin
            ifu_resp_valid = 1'b1;
            ifu_resp_rdata = w_resp_fire ? mem_resp_rdata : '0;
            ifu_resp_err   = w_resp_fire ? mem_resp_err : 1'b1;
          end else begin
            lsu_resp_valid = 1'b1;
            lsu_resp_rdata = w_resp_fire ? mem_resp_rdata : '0;
            lsu_resp_err   = w_resp_fire ? mem_resp_err : 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch the granted request; IFU fetches become full-word reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= M_IFU;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_gnt_valid) begin
      r_owner <= master_e'(w_gnt_id);
      if (w_gnt_id == M_LSU) begin
        r_addr  <= lsu_addr;
        r_wen   <= lsu_wen;
        r_wdata <= lsu_wdata;
        r_wmask <= lsu_wmask;
      end else begin
        r_addr  <= ifu_addr;
        r_wen   <= 1'b0;
        r_wdata <= '0;
        r_wmask <= '1;
      end
    end
  end

  // Watchdog: cleared while the request is issued, counts in S_RESP, saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == S_REQ) begin
      r_cnt <= '0;
    end else if ((r_state == S_RESP) && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Sticky flag for a slave response arriving when nothing is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_spurious <= 1'b0;
    end else if (mem_resp_valid && (r_state != S_RESP)) begin
      r_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_mem_arb.sv
// Directed bench for the IFU/LSU memory arbiter. Inputs change just after the
// falling edge; outputs are sampled 1 time unit later, well away from posedge.
module tb_ysyx_25020047_mem_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ifu_req_valid, ifu_req_ready;
  logic [AW-1:0] ifu_addr;
  logic          ifu_resp_valid;
  logic [DW-1:0] ifu_resp_rdata;
  logic          ifu_resp_err;
  logic          lsu_req_valid, lsu_req_ready;
  logic [AW-1:0] lsu_addr;
  logic          lsu_wen;
  logic [DW-1:0] lsu_wdata;
  logic [MW-1:0] lsu_wmask;
  logic          lsu_resp_valid;
  logic [DW-1:0] lsu_resp_rdata;
  logic          lsu_resp_err;
  logic          mem_req_valid, mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_rdata;
  logic          mem_resp_err;
  logic          spurious_resp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_25020047_mem_arb #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_rdata (ifu_resp_rdata),
    .ifu_resp_err   (ifu_resp_err),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_rdata (lsu_resp_rdata),
    .lsu_resp_err   (lsu_resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .mem_resp_err   (mem_resp_err),
    .spurious_resp  (spurious_resp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Absolute safety net; the directed sequence ends far earlier.
  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    ifu_req_valid = 1'b1; ifu_addr = '0;
    lsu_req_valid = 1'b1; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0; mem_resp_err = 1'b0;

    // ---- reset state (requests held high during reset must not be accepted)
    cyc(); cyc(); #1;
    check("rst_ifu_rdy",  32'(ifu_req_ready),  32'h0);
    check("rst_lsu_rdy",  32'(lsu_req_ready),  32'h0);
    check("rst_mreq_vld", 32'(mem_req_valid),  32'h0);
    check("rst_maddr",    mem_addr,            32'h0);
    check("rst_mwdata",   mem_wdata,           32'h0);
    check("rst_mwmask",   32'(mem_wmask),      32'h0);
    check("rst_mwen",     32'(mem_wen),        32'h0);
    check("rst_ifu_rv",   32'(ifu_resp_valid), 32'h0);
    check("rst_lsu_rv",   32'(lsu_resp_valid), 32'h0);
    check("rst_spur",     32'(spurious_resp),  32'h0);

    // ---- contention right after reset: IFU first, then LSU, then IFU again
    cyc(); rst = 1'b0; ifu_addr = 32'h8000_0010; lsu_addr = 32'h8000_2000; lsu_wmask = 4'hF; #1;
    check("rr1_ifu_rdy", 32'(ifu_req_ready), 32'h1);
    check("rr1_lsu_rdy", 32'(lsu_req_ready), 32'h0);
    cyc(); ifu_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
    check("rr1_maddr",    mem_addr,           32'h8000_0010);
    check("rr1_lsu_rdy2", 32'(lsu_req_ready), 32'h0);
    cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h11; #1;
    check("rr1_ifu_rv",   32'(ifu_resp_valid), 32'h1);
    check("rr1_ifu_rd",   ifu_resp_rdata,      32'h11);
    check("rr1_lsu_rv",   32'(lsu_resp_valid), 32'h0);
    cyc(); mem_resp_valid = 1'b0; #1;
    check("rr2_lsu_rdy", 32'(lsu_req_ready),  32'h1);
    check("rr2_ifu_rv",  32'(ifu_resp_valid), 32'h0);
    cyc(); lsu_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
    check("rr2_maddr",  mem_addr,        32'h8000_2000);
    check("rr2_mwen",   32'(mem_wen),    32'h0);
    check("rr2_mwmask", 32'(mem_wmask),  32'hF);
    cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h22; #1;
    check("rr2_lsu_rv", 32'(lsu_resp_valid), 32'h1);
    check("rr2_lsu_rd", lsu_resp_rdata,      32'h22);
    check("rr2_ifu_rv", 32'(ifu_resp_valid), 32'h0);
    cyc(); mem_resp_valid = 1'b0; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0020; #1;
    check("rr3_ifu_rdy", 32'(ifu_req_ready), 32'h1);
    check("rr3_lsu_rdy", 32'(lsu_req_ready), 32'h0);
    cyc(); ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
    check("rr3_maddr", mem_addr, 32'h8000_0020);
    cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h33; #1;
    check("rr3_ifu_rv", 32'(ifu_resp_valid), 32'h1);

    // ---- IFU only, minimum latency
    cyc(); mem_resp_valid = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1; #1;
    check("lat_ifu_rdy_N",  32'(ifu_req_ready), 32'h1);
    check("lat_mreq_vld_N", 32'(mem_req_valid), 32'h0);
    cyc(); ifu_req_valid = 1'b0; ifu_addr = 32'h1234_5678; #1;
    check("lat_mreq_vld_N1", 32'(mem_req_valid), 32'h1);
    check("lat_maddr",       mem_addr,           32'h8000_0000);
    check("lat_mwen",        32'(mem_wen),       32'h0);
    check("lat_mwmask",      32'(mem_wmask),     32'hF);
    check("lat_ifu_rdy_N1",  32'(ifu_req_ready), 32'h0);
    cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0000_0413; mem_resp_err = 1'b0; #1;
    check("lat_ifu_rv_N2", 32'(ifu_resp_valid), 32'h1);
    check("lat_ifu_rd",    ifu_resp_rdata,      32'h0000_0413);
    check("lat_ifu_err",   32'(ifu_resp_err),   32'h0);
    check("lat_lsu_rv",    32'(lsu_resp_valid), 32'h0);
    cyc(); mem_resp_valid = 1'b0; #1;
    check("lat_ifu_rv_off", 32'(ifu_resp_valid), 32'h0);
    check("lat_mreq_off",   32'(mem_req_valid),  32'h0);

    // ---- LSU store with slave back-pressure for 3 cycles
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1002; lsu_wen = 1'b1;
    lsu_wdata = 32'hABCD_0000; lsu_wmask = 4'hC; #1;
    check("st_lsu_rdy", 32'(lsu_req_ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc(); lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'hFFFF_FFFF; lsu_wmask = 4'h3; #1;
      check("st_hold_vld",   32'(mem_req_valid), 32'h1);
      check("st_hold_addr",  mem_addr,           32'h8000_1002);
      check("st_hold_wdata", mem_wdata,          32'hABCD_0000);
      check("st_hold_wmask", 32'(mem_wmask),     32'hC);
      check("st_hold_wen",   32'(mem_wen),       32'h1);
    end
    cyc(); mem_req_ready = 1'b1; #1;
    check("st_acc_vld", 32'(mem_req_valid), 32'h1);
    cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0; #1;
    check("st_lsu_rv",  32'(lsu_resp_valid), 32'h1);
    check("st_lsu_err", 32'(lsu_resp_err),   32'h0);
    cyc(); mem_resp_valid = 1'b0; #1;
    check("st_lsu_rv_once", 32'(lsu_resp_valid), 32'h0);

    // ---- watchdog with TIMEOUT=4, then a late response
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100; lsu_wen = 1'b0; #1;
    check("to_ifu_rdy", 32'(ifu_req_ready), 32'h1);
    cyc(); ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    cyc(); mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; check("to_wait_rv", 32'(ifu_resp_valid), 32'h0);
      cyc();
    end
    #1;
    check("to_ifu_rv",  32'(ifu_resp_valid), 32'h1);
    check("to_ifu_err", 32'(ifu_resp_err),   32'h1);
    check("to_ifu_rd",  ifu_resp_rdata,      32'h0);
    check("to_lsu_rv",  32'(lsu_resp_valid), 32'h0);
    cyc(); #1;
    check("to_after_rv", 32'(ifu_resp_valid), 32'h0);
    cyc(); mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5; #1;
    check("late_ifu_rv", 32'(ifu_resp_valid), 32'h0);
    check("late_lsu_rv", 32'(lsu_resp_valid), 32'h0);
    check("late_spur0",  32'(spurious_resp),  32'h0);
    cyc(); mem_resp_valid = 1'b0; #1;
    check("late_spur1", 32'(spurious_resp), 32'h1);
    cyc(); #1;
    check("late_spur_sticky", 32'(spurious_resp), 32'h1);

    // ---- reset while waiting in S_RESP
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200; #1;
    check("mr_ifu_rdy", 32'(ifu_req_ready), 32'h1);
    cyc(); ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    cyc(); mem_req_ready = 1'b0; rst = 1'b1; #1;
    check("mr_rst_rv", 32'(ifu_resp_valid), 32'h0);
    cyc(); rst = 1'b0; #1;
    check("mr_mreq_vld", 32'(mem_req_valid),  32'h0);
    check("mr_maddr",    mem_addr,            32'h0);
    check("mr_mwmask",   32'(mem_wmask),      32'h0);
    check("mr_spur",     32'(spurious_resp),  32'h0);
    check("mr_ifu_rv",   32'(ifu_resp_valid), 32'h0);
    cyc(); #1;
    check("mr_no_pulse", 32'(ifu_resp_valid), 32'h0);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0300; #1;
    check("mr_new_rdy", 32'(ifu_req_ready), 32'h1);
    cyc(); ifu_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
    check("mr_new_maddr", mem_addr, 32'h8000_0300);
    cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h44; #1;
    check("mr_new_rv", 32'(ifu_resp_valid), 32'h1);
    check("mr_new_rd", ifu_resp_rdata,      32'h44);

    // ---- slave error on an LSU load, then normal service continues
    cyc(); mem_resp_valid = 1'b0;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0400; lsu_wen = 1'b0; lsu_wmask = 4'hF; #1;
    check("er_lsu_rdy", 32'(lsu_req_ready), 32'h1);
    cyc(); lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_err = 1'b1; mem_resp_rdata = 32'hDEAD_BEEF; #1;
    check("er_lsu_rv",  32'(lsu_resp_valid), 32'h1);
    check("er_lsu_err", 32'(lsu_resp_err),   32'h1);
    check("er_lsu_rd",  lsu_resp_rdata,      32'hDEAD_BEEF);
    check("er_ifu_rv",  32'(ifu_resp_valid), 32'h0);
    check("er_ifu_err", 32'(ifu_resp_err),   32'h0);
    cyc(); mem_resp_valid = 1'b0; mem_resp_err = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0500; #1;
    check("er_next_rdy", 32'(ifu_req_ready), 32'h1);
    cyc(); ifu_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
    check("er_next_maddr", mem_addr, 32'h8000_0500);
    cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h55; #1;
    check("er_next_rv",  32'(ifu_resp_valid), 32'h1);
    check("er_next_err", 32'(ifu_resp_err),   32'h0);
    check("er_next_rd",  ifu_resp_rdata,      32'h55);
    cyc(); mem_resp_valid = 1'b0; #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
